// File: rtl/rv32_pkg.sv
// rv32_pkg: definitions shared by the RV32IM core front end.
//   XLEN / ILEN      : data and instruction widths
//   DEFAULT_RESET_PC : PC loaded by reset unless a block overrides it
//   fetch_state_e    : outstanding-request tracker used by fetch_unit
//   word_addr()      : rebuilds a word-aligned byte address from a word index
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // IDLE: nothing outstanding; BUSY: one live request; DROP: one stale request
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-3:0] word_index);
    return {word_index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO of {pc, instr} between fetch and decode.
//   clk, rst             : clock, synchronous active-high reset (clears storage)
//   push, push_pc/instr  : write one entry
//   pop                  : consume the head (ignored when empty)
//   flush                : empty the queue; wins over push and pop
//   occ                  : current occupancy (0..2)
//   head_valid/pc/instr  : registered head entry presented to decode
module fetch_queue
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [ILEN-1:0] push_instr,
  input  logic            pop,
  input  logic            flush,
  output logic [1:0]      occ,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_instr
);

  logic [XLEN-1:0] pc_mem_r    [2];
  logic [ILEN-1:0] instr_mem_r [2];
  logic            rd_ptr_r;
  logic            wr_ptr_r;
  logic [1:0]      occ_r;
  logic            do_push_s;
  logic            do_pop_s;

  // Qualify push/pop: a full queue only takes a push when the head leaves too
  always_comb begin
    do_pop_s  = pop && (occ_r != 2'd0);
    do_push_s = push && ((occ_r != 2'd2) || do_pop_s);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_mem_r[0]    <= {XLEN{1'b0}};
      pc_mem_r[1]    <= {XLEN{1'b0}};
      instr_mem_r[0] <= {ILEN{1'b0}};
      instr_mem_r[1] <= {ILEN{1'b0}};
      rd_ptr_r       <= 1'b0;
      wr_ptr_r       <= 1'b0;
      occ_r          <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (do_push_s) begin
        pc_mem_r[wr_ptr_r]    <= push_pc;
        instr_mem_r[wr_ptr_r] <= push_instr;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  assign occ        = occ_r;
  assign head_valid = (occ_r != 2'd0);
  assign head_pc    = pc_mem_r[rd_ptr_r];
  assign head_instr = instr_mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the RV32IM core.
// Holds the PC, issues one word request at a time to instruction memory and
// buffers responses in a 2-entry queue for decode. A redirect from execute
// reloads the PC, flushes the queue and marks any in-flight request stale.
//   clk, rst                      : clock, synchronous active-high reset
//   redirect_valid, redirect_pc   : taken branch/jump target from execute
//   imem_req_valid/ready/addr     : request handshake (addr == pc)
//   imem_rsp_valid/data           : in-order response, no backpressure
//   if_valid, if_pc, if_instr     : queue head to decode
//   id_ready                      : decode consumes the head
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  fetch_state_e    state_r;
  fetch_state_e    state_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic [1:0]      occ_s;
  logic            pop_s;
  logic            push_s;
  logic            accept_s;
  logic            outstanding_s;
  logic            issue_ok_s;
  logic            room_s;
  logic [1:0]      unused_redirect_lsb_s;

  // Redirect targets are word aligned; the low bits carry no information
  assign unused_redirect_lsb_s = redirect_pc[1:0];

  // Request / push / pop decisions for this cycle
  always_comb begin
    pop_s         = if_valid && id_ready;
    outstanding_s = (state_r == BUSY);
    // A new request may only go out once the slot for its response is
    // guaranteed: queued entries plus the live response still to land,
    // minus what decode drains this cycle, must leave one place free.
    room_s        = ({1'b0, occ_s} + {2'b00, outstanding_s}) < (3'd2 + {2'b00, pop_s});
    // With one request in flight, the next may overlap only its response cycle
    issue_ok_s    = (state_r == IDLE) || imem_rsp_valid;
    imem_req_valid = !rst && !redirect_valid && issue_ok_s && room_s;
    accept_s      = imem_req_valid && imem_req_ready;
    // Stale (DROP) responses and responses racing a redirect are discarded
    push_s        = (state_r == BUSY) && imem_rsp_valid && !redirect_valid;
  end

  // Next-state logic for the outstanding-request tracker
  always_comb begin
    state_s = state_r;
    if (redirect_valid) begin
      case (state_r)
        IDLE:    state_s = IDLE;
        BUSY:    state_s = imem_rsp_valid ? IDLE : DROP;
        DROP:    state_s = imem_rsp_valid ? IDLE : DROP;
        default: state_s = IDLE;
      endcase
    end else if (accept_s) begin
      state_s = BUSY;
    end else if (imem_rsp_valid) begin
      state_s = IDLE;
    end else begin
      state_s = state_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // PC and the PC of the live request; redirect beats an accept
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      req_pc_r <= {XLEN{1'b0}};
    end else if (redirect_valid) begin
      pc_r <= word_addr(redirect_pc[XLEN-1:2]);
    end else if (accept_s) begin
      req_pc_r <= pc_r;
      pc_r     <= pc_r + 32'd4;
    end
  end

  assign imem_req_addr = pc_r;

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_pc    (req_pc_r),
    .push_instr (imem_rsp_data),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .occ        (occ_s),
    .head_valid (if_valid),
    .head_pc    (if_pc),
    .head_instr (if_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// A small in-order memory model answers accepted requests after a
// configurable latency; every pop is compared against the expected
// sequential stream starting from the last reset/redirect target.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  // second instance for the PC wrap case
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;
  logic        w_id_ready;

  int checks;
  int errors;

  // memory model
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat;

  // expected stream
  logic [31:0] exp_pc;
  int          pop_cnt;

  // per-cycle snapshot
  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_if_valid;
  logic [31:0] obs_if_pc;
  logic [31:0] obs_if_instr;
  logic        obs_w_req_valid;
  logic [31:0] obs_w_req_addr;
  logic        obs_w_if_valid;
  logic [31:0] obs_w_if_pc;
  logic [31:0] obs_w_if_instr;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_ready       (id_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_req_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .if_valid       (w_if_valid),
    .if_pc          (w_if_pc),
    .if_instr       (w_if_instr),
    .id_ready       (w_id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive the memory response, sample, advance the model.
  task automatic cycle();
    imem_rsp_valid = mem_pend && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? instr_of(mem_addr) : 32'h0000_0000;
    #1;
    obs_req_valid   = imem_req_valid;
    obs_req_addr    = imem_req_addr;
    obs_if_valid    = if_valid;
    obs_if_pc       = if_pc;
    obs_if_instr    = if_instr;
    obs_w_req_valid = w_req_valid;
    obs_w_req_addr  = w_req_addr;
    obs_w_if_valid  = w_if_valid;
    obs_w_if_pc     = w_if_pc;
    obs_w_if_instr  = w_if_instr;
    if (obs_if_valid && id_ready && !rst) begin
      chk("pop_pc", obs_if_pc, exp_pc);
      chk("pop_instr", obs_if_instr, instr_of(exp_pc));
      exp_pc  = exp_pc + 32'd4;
      pop_cnt = pop_cnt + 1;
    end
    if (obs_req_valid && imem_req_ready) begin
      chk("one_outst", 32'(mem_pend && !imem_rsp_valid), 32'd0);
    end
    if (rst) begin
      mem_pend = 1'b0;
    end else begin
      if (imem_rsp_valid) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt = mem_cnt - 1;
      if (obs_req_valid && imem_req_ready) begin
        mem_pend = 1'b1;
        mem_addr = obs_req_addr;
        mem_cnt  = lat - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    chk("rst_req_valid", 32'(obs_req_valid), 32'd0);
    chk("rst_if_valid", 32'(obs_if_valid), 32'd0);
    chk("rst_if_pc", obs_if_pc, 32'h0000_0000);
    chk("rst_if_instr", obs_if_instr, 32'h0000_0000);
    rst     = 1'b0;
    exp_pc  = 32'h0000_0000;
    pop_cnt = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    mem_pend = 1'b0; mem_addr = 32'h0; mem_cnt = 0; lat = 1;
    exp_pc = 32'h0; pop_cnt = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    id_ready = 1'b0;
    w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_req_ready = 1'b0;
    w_rsp_valid = 1'b0; w_rsp_data = 32'h0; w_id_ready = 1'b0;
    @(negedge clk);

    // PC wrap and redirect alignment on the RESET_PC = 0xFFFF_FFFC instance
    do_reset();
    w_req_ready = 1'b1;
    cycle();
    chk("wrap_req_valid", 32'(obs_w_req_valid), 32'd1);
    chk("wrap_req_addr", obs_w_req_addr, 32'hFFFF_FFFC);
    w_req_ready = 1'b0; w_rsp_valid = 1'b1; w_rsp_data = 32'h1234_5678;
    cycle();
    chk("wrap_next_valid", 32'(obs_w_req_valid), 32'd1);
    chk("wrap_next_addr", obs_w_req_addr, 32'h0000_0000);
    w_rsp_valid = 1'b0; w_redirect_valid = 1'b1; w_redirect_pc = 32'h0000_0103;
    cycle();
    chk("wrap_if_valid", 32'(obs_w_if_valid), 32'd1);
    chk("wrap_if_pc", obs_w_if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_instr", obs_w_if_instr, 32'h1234_5678);
    chk("wrap_redir_noreq", 32'(obs_w_req_valid), 32'd0);
    w_redirect_valid = 1'b0;
    cycle();
    chk("wrap_flush", 32'(obs_w_if_valid), 32'd0);
    chk("align_req_valid", 32'(obs_w_req_valid), 32'd1);
    chk("align_req_addr", obs_w_req_addr, 32'h0000_0100);

    // Streaming with 1-cycle memory and decode always ready
    imem_req_ready = 1'b1; id_ready = 1'b1; lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t1_req_valid", 32'(obs_req_valid), 32'd1);
      chk("t1_req_addr", obs_req_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("t1_if_valid", 32'(obs_if_valid), 32'd1);
        chk("t1_if_pc", obs_if_pc, 32'(4 * (i - 2)));
      end
    end

    // Decode stalls for 5 cycles: queue fills, requests stop
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_no_req", 32'(obs_req_valid), 32'd0);
    end
    chk("t2_head_valid", 32'(obs_if_valid), 32'd1);
    chk("t2_head_pc", obs_if_pc, 32'h0000_0010);
    chk("t2_outst", 32'(mem_pend), 32'd0);
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_pop_cnt", 32'(pop_cnt), 32'd10);

    // Redirect with a request outstanding; stale response 2 cycles later
    id_ready = 1'b0; lat = 3;
    do_reset();
    cycle();
    chk("t3_req0", obs_req_addr, 32'h0000_0000);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    chk("t3_redir_noreq", 32'(obs_req_valid), 32'd0);
    redirect_valid = 1'b0; exp_pc = 32'h0000_0100;
    cycle();
    chk("t3_drop_noreq", 32'(obs_req_valid), 32'd0);
    chk("t3_drop_empty", 32'(obs_if_valid), 32'd0);
    cycle();
    chk("t3_new_req_valid", 32'(obs_req_valid), 32'd1);
    chk("t3_new_req_addr", obs_req_addr, 32'h0000_0100);
    cycle();
    chk("t3_discard", 32'(obs_if_valid), 32'd0);
    lat = 1;
    cycle();
    cycle();
    id_ready = 1'b1;
    cycle();
    chk("t3_if_valid", 32'(obs_if_valid), 32'd1);
    chk("t3_if_pc", obs_if_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop
    do_reset();
    cycle();
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    chk("t4_redir_noreq", 32'(obs_req_valid), 32'd0);
    redirect_valid = 1'b0; exp_pc = 32'h0000_0100;
    cycle();
    chk("t4_flushed", 32'(obs_if_valid), 32'd0);
    chk("t4_req_valid", 32'(obs_req_valid), 32'd1);
    chk("t4_req_addr", obs_req_addr, 32'h0000_0100);
    cycle();
    cycle();
    chk("t4_if_pc", obs_if_pc, 32'h0000_0100);

    // Memory stalls for 4 cycles, then reset in the middle of the stall
    imem_req_ready = 1'b0;
    cycle();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_hold_valid", 32'(obs_req_valid), 32'd1);
    chk("t6_hold_addr", obs_req_addr, 32'h0000_010C);
    chk("t6_head_valid", 32'(obs_if_valid), 32'd1);
    chk("t6_head_pc", obs_if_pc, 32'h0000_0108);
    rst = 1'b1;
    cycle();
    chk("t6_rst_noreq", 32'(obs_req_valid), 32'd0);
    cycle();
    chk("t6_rst_if_valid", 32'(obs_if_valid), 32'd0);
    chk("t6_rst_if_pc", obs_if_pc, 32'h0000_0000);
    rst = 1'b0; exp_pc = 32'h0000_0000;
    cycle();
    chk("t6_rel_req_valid", 32'(obs_req_valid), 32'd1);
    chk("t6_rel_req_addr", obs_req_addr, 32'h0000_0000);
    chk("t6_rel_if_valid", 32'(obs_if_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
